// File: rtl/bp_me_mem_cmd_arbiter_if.sv
// Bundle of the two requester channels and the shared memory channel of the
// memory-command arbiter; slave is the arbiter side, master the environment.
interface bp_me_mem_cmd_arbiter_if #(parameter int msg_width_p = 512);
    logic [msg_width_p-1:0] req0_cmd_i, req1_cmd_i;
    logic                   req0_cmd_v_i, req1_cmd_v_i;
    logic                   req0_cmd_yumi_o, req1_cmd_yumi_o;
    logic [msg_width_p-1:0] req0_resp_o, req1_resp_o;
    logic                   req0_resp_v_o, req1_resp_v_o;
    logic                   req0_resp_ready_i, req1_resp_ready_i;
    logic [msg_width_p-1:0] mem_cmd_o;
    logic                   mem_cmd_v_o;
    logic                   mem_cmd_ready_i;
    logic [msg_width_p-1:0] mem_resp_i;
    logic                   mem_resp_v_i;
    logic                   mem_resp_yumi_o;
    logic                   idle_o;

    modport slave (
        input  req0_cmd_i, req0_cmd_v_i, req0_resp_ready_i,
        input  req1_cmd_i, req1_cmd_v_i, req1_resp_ready_i,
        input  mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
        output req0_cmd_yumi_o, req0_resp_o, req0_resp_v_o,
        output req1_cmd_yumi_o, req1_resp_o, req1_resp_v_o,
        output mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, idle_o
    );

    modport master (
        output req0_cmd_i, req0_cmd_v_i, req0_resp_ready_i,
        output req1_cmd_i, req1_cmd_v_i, req1_resp_ready_i,
        output mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
        input  req0_cmd_yumi_o, req0_resp_o, req0_resp_v_o,
        input  req1_cmd_yumi_o, req1_resp_o, req1_resp_v_o,
        input  mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, idle_o
    );
endinterface

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory command port between two requesters;
// an order FIFO of requester IDs steers in-order responses back and caps credits.
module bp_me_mem_cmd_arbiter #(
    parameter int msg_width_p       = 512,
    parameter int max_outstanding_p = 4
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    bp_me_mem_cmd_arbiter_if.slave   bus
);
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_w_lp = $clog2(max_outstanding_p);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_outstanding_p);

    logic [msg_width_p-1:0]       cmd_q, cmd_d;
    logic                         cmd_v_q, cmd_v_d;
    logic [cnt_w_lp-1:0]          count_q, count_d;
    logic [ptr_w_lp-1:0]          wptr_q, rptr_q;
    logic [max_outstanding_p-1:0] id_q;
    logic                         last_q;

    logic [1:0] cmd_v;
    logic       win, grant, head, nonempty, resp_v, pop;

    assign cmd_v = {bus.req1_cmd_v_i, bus.req0_cmd_v_i};

    // Grant is held off during reset so no yumi leaks while state is cleared.
    always_comb begin
        win      = (&cmd_v) ? ~last_q : cmd_v[1];
        grant    = reset_n_i & (|cmd_v) & (~cmd_v_q | bus.mem_cmd_ready_i)
                   & (count_q < max_cnt_lp);
        head     = id_q[rptr_q];
        nonempty = (count_q != '0);
        resp_v   = bus.mem_resp_v_i & nonempty;
        pop      = resp_v & (head ? bus.req1_resp_ready_i : bus.req0_resp_ready_i);
        count_d  = count_q + cnt_w_lp'(grant) - cnt_w_lp'(pop);
        cmd_d    = cmd_q;
        cmd_v_d  = cmd_v_q & ~bus.mem_cmd_ready_i;
        if (grant) begin
            cmd_d   = win ? bus.req1_cmd_i : bus.req0_cmd_i;
            cmd_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_q   <= '0;
            cmd_v_q <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b1;
        end else begin
            cmd_q   <= cmd_d;
            cmd_v_q <= cmd_v_d;
            count_q <= count_d;
            if (grant) begin
                id_q[wptr_q] <= win;
                wptr_q       <= wptr_q + ptr_w_lp'(1);
                last_q       <= win;
            end
            if (pop) rptr_q <= rptr_q + ptr_w_lp'(1);
        end
    end

    assign bus.req0_cmd_yumi_o = grant & ~win;
    assign bus.req1_cmd_yumi_o = grant & win;
    assign bus.mem_cmd_o       = cmd_q;
    assign bus.mem_cmd_v_o     = cmd_v_q;
    assign bus.req0_resp_o     = bus.mem_resp_i;
    assign bus.req1_resp_o     = bus.mem_resp_i;
    assign bus.req0_resp_v_o   = resp_v & ~head;
    assign bus.req1_resp_v_o   = resp_v & head;
    assign bus.mem_resp_yumi_o = pop;
    assign bus.idle_o          = ~nonempty & ~cmd_v_q;
endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Bench for the memory-command arbiter: table of arbitration vectors plus
// hand sequences; command and response-order scoreboards fed at stimulus time.
module tb_bp_me_mem_cmd_arbiter;
    localparam int W  = 512;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_me_mem_cmd_arbiter_if #(.msg_width_p(W)) bus ();
    bp_me_mem_cmd_arbiter #(.msg_width_p(W), .max_outstanding_p(MO)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
    );

    typedef struct { logic v0, v1, y0, y1; } vec_t;
    vec_t tbl [6];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] cmd_sb [$];
    bit           ord_q  [$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit id, input logic [W-1:0] d);
        cmd_sb.push_back(d);
        ord_q.push_back(id);
    endtask

    // Drive one memory response and check its routing to the expected head requester.
    task automatic resp_one(input logic r0, input logic r1, input logic exp_yumi);
        logic [W-1:0] d;
        bit h;
        d = {16{$urandom()}};
        bus.mem_resp_v_i      = 1'b1;
        bus.mem_resp_i        = d;
        bus.req0_resp_ready_i = r0;
        bus.req1_resp_ready_i = r1;
        #1;
        if (ord_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_order actual=empty required=entry");
        end else begin
            h = ord_q[0];
            chk1("resp_v0", bus.req0_resp_v_o, ~h);
            chk1("resp_v1", bus.req1_resp_v_o, h);
            chkw("resp_data", h ? bus.req1_resp_o : bus.req0_resp_o, d);
            chk1("resp_yumi", bus.mem_resp_yumi_o, exp_yumi);
            if (exp_yumi) void'(ord_q.pop_front());
        end
    endtask

    // Commands are accepted on the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (rst_n && bus.mem_cmd_v_o && bus.mem_cmd_ready_i) begin
            if (cmd_sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_cmd_spurious actual=%0h required=none", bus.mem_cmd_o);
            end else begin
                chkw("mem_cmd", bus.mem_cmd_o, cmd_sb.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] w0, w1;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0};  // first tie goes to req0
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};  // lone requester wins
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0};  // four outstanding: no grant
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0};

        bus.req0_cmd_i = '0; bus.req1_cmd_i = '0;
        bus.req0_cmd_v_i = 1'b0; bus.req1_cmd_v_i = 1'b0;
        bus.req0_resp_ready_i = 1'b1; bus.req1_resp_ready_i = 1'b1;
        bus.mem_cmd_ready_i = 1'b1;
        bus.mem_resp_i = '0; bus.mem_resp_v_i = 1'b0;

        #2;
        chk1("rst_cmd_v", bus.mem_cmd_v_o, 1'b0);
        chk1("rst_idle", bus.idle_o, 1'b1);
        chk1("rst_yumi0", bus.req0_cmd_yumi_o, 1'b0);
        chk1("rst_resp_yumi", bus.mem_resp_yumi_o, 1'b0);
        #10 rst_n = 1'b1;
        cyc();

        // Table: arbitration and credit limit
        for (int r = 0; r < 6; r++) begin
            w0 = {16{32'(32'hA000_0000 + r)}};
            w1 = {16{32'(32'hB000_0000 + r)}};
            bus.req0_cmd_v_i = tbl[r].v0; bus.req1_cmd_v_i = tbl[r].v1;
            bus.req0_cmd_i = w0; bus.req1_cmd_i = w1;
            #1;
            chk1($sformatf("tbl%0d_y0", r), bus.req0_cmd_yumi_o, tbl[r].y0);
            chk1($sformatf("tbl%0d_y1", r), bus.req1_cmd_yumi_o, tbl[r].y1);
            if (tbl[r].y0) issue(1'b0, w0);
            if (tbl[r].y1) issue(1'b1, w1);
            cyc();
        end
        bus.req0_cmd_v_i = 1'b0; bus.req1_cmd_v_i = 1'b0;
        #1;
        chk1("full_idle", bus.idle_o, 1'b0);

        // Full: a pop does not free a credit in the same cycle
        w1 = {16{32'hF1F1_0005}};
        bus.req1_cmd_v_i = 1'b1; bus.req1_cmd_i = w1;
        resp_one(1'b1, 1'b1, 1'b1);
        chk1("full_pop_no_grant", bus.req1_cmd_yumi_o, 1'b0);
        cyc();
        bus.mem_resp_v_i = 1'b0;
        #1;
        chk1("full_next_grant", bus.req1_cmd_yumi_o, 1'b1);
        issue(1'b1, w1);
        cyc();
        bus.req1_cmd_v_i = 1'b0;

        // Response backpressure on head ID 1
        resp_one(1'b1, 1'b0, 1'b0);
        cyc();
        resp_one(1'b1, 1'b0, 1'b0);
        cyc();
        resp_one(1'b1, 1'b1, 1'b1);
        cyc();
        while (ord_q.size() != 0) begin
            resp_one(1'b1, 1'b1, 1'b1);
            cyc();
        end
        bus.mem_resp_v_i = 1'b0;
        #1;
        chk1("drain_idle", bus.idle_o, 1'b1);

        // Response with nothing outstanding is ignored
        bus.mem_resp_v_i = 1'b1;
        #1;
        chk1("empty_resp_yumi", bus.mem_resp_yumi_o, 1'b0);
        chk1("empty_resp_v0", bus.req0_resp_v_o, 1'b0);
        chk1("empty_resp_v1", bus.req1_resp_v_o, 1'b0);
        bus.mem_resp_v_i = 1'b0;
        cyc();

        // Output stall: command held, no grants, then the other requester wins
        w0 = {16{32'h5151_0000}}; w1 = {16{32'h5252_0000}};
        bus.req0_cmd_v_i = 1'b1; bus.req1_cmd_v_i = 1'b1;
        bus.req0_cmd_i = w0; bus.req1_cmd_i = w1;
        #1;
        chk1("stall_g_y0", bus.req0_cmd_yumi_o, 1'b1);
        chk1("stall_g_y1", bus.req1_cmd_yumi_o, 1'b0);
        issue(1'b0, w0);
        cyc();
        bus.mem_cmd_ready_i = 1'b0;
        bus.req0_cmd_i = {16{32'h5353_0000}};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall_y0", bus.req0_cmd_yumi_o, 1'b0);
            chk1("stall_y1", bus.req1_cmd_yumi_o, 1'b0);
            chk1("stall_v", bus.mem_cmd_v_o, 1'b1);
            chkw("stall_hold", bus.mem_cmd_o, w0);
            cyc();
        end
        bus.mem_cmd_ready_i = 1'b1;
        #1;
        chk1("unstall_y0", bus.req0_cmd_yumi_o, 1'b0);
        chk1("unstall_y1", bus.req1_cmd_yumi_o, 1'b1);
        issue(1'b1, w1);
        cyc();
        bus.req0_cmd_v_i = 1'b0; bus.req1_cmd_v_i = 1'b0;
        cyc();
        while (ord_q.size() != 0) begin
            resp_one(1'b1, 1'b1, 1'b1);
            cyc();
        end
        bus.mem_resp_v_i = 1'b0;

        // Single request with 0 cycle response
        w0 = {64{8'hA5}};
        bus.req0_cmd_v_i = 1'b1; bus.req0_cmd_i = w0;
        #1;
        chk1("single_yumi", bus.req0_cmd_yumi_o, 1'b1);
        issue(1'b0, w0);
        cyc();
        bus.req0_cmd_v_i = 1'b0;
        chk1("single_cmd_v", bus.mem_cmd_v_o, 1'b1);
        chkw("single_cmd", bus.mem_cmd_o, w0);
        resp_one(1'b1, 1'b1, 1'b1);
        cyc();
        bus.mem_resp_v_i = 1'b0;
        #1;
        chk1("single_idle", bus.idle_o, 1'b1);

        // Async reset with three outstanding and a command parked in the stage
        for (int i = 0; i < 3; i++) begin
            w0 = {16{32'(32'hC000_0000 + i)}};
            bus.req0_cmd_v_i = 1'b1; bus.req0_cmd_i = w0;
            #1;
            chk1("pre_rst_yumi", bus.req0_cmd_yumi_o, 1'b1);
            issue(1'b0, w0);
            cyc();
        end
        bus.req0_cmd_v_i = 1'b0; bus.mem_cmd_ready_i = 1'b0;
        #1;
        chk1("pre_rst_v", bus.mem_cmd_v_o, 1'b1);
        chk1("pre_rst_idle", bus.idle_o, 1'b0);
        bus.req0_cmd_v_i = 1'b1; bus.mem_resp_v_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk1("arst_cmd_v", bus.mem_cmd_v_o, 1'b0);
        chk1("arst_idle", bus.idle_o, 1'b1);
        chk1("arst_y0", bus.req0_cmd_yumi_o, 1'b0);
        chk1("arst_y1", bus.req1_cmd_yumi_o, 1'b0);
        chk1("arst_rv0", bus.req0_resp_v_o, 1'b0);
        chk1("arst_rv1", bus.req1_resp_v_o, 1'b0);
        chk1("arst_ryumi", bus.mem_resp_yumi_o, 1'b0);
        cmd_sb.delete(); ord_q.delete();
        bus.req0_cmd_v_i = 1'b0; bus.mem_resp_v_i = 1'b0; bus.mem_cmd_ready_i = 1'b1;
        rst_n = 1'b1;
        cyc();

        // Contention after reset with prompt responses: 0,1,0,1,0,1
        for (int k = 0; k < 6; k++) begin
            w0 = {16{32'(32'hD000_0000 + k)}};
            w1 = {16{32'(32'hE000_0000 + k)}};
            bus.req0_cmd_v_i = 1'b1; bus.req1_cmd_v_i = 1'b1;
            bus.req0_cmd_i = w0; bus.req1_cmd_i = w1;
            if (k > 0) resp_one(1'b1, 1'b1, 1'b1);
            else #1;
            chk1($sformatf("cont%0d_y0", k), bus.req0_cmd_yumi_o, (k % 2) == 0);
            chk1($sformatf("cont%0d_y1", k), bus.req1_cmd_yumi_o, (k % 2) == 1);
            if ((k % 2) == 0) issue(1'b0, w0); else issue(1'b1, w1);
            cyc();
        end
        bus.req0_cmd_v_i = 1'b0; bus.req1_cmd_v_i = 1'b0;
        resp_one(1'b1, 1'b1, 1'b1);
        cyc();
        bus.mem_resp_v_i = 1'b0;
        #1;
        chk1("cont_idle", bus.idle_o, 1'b1);
        chkw("cmd_sb_empty", W'(cmd_sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
